uart_tx: RTL and testbench

- Byte-wide UART transmitter: serializes an 8-bit word onto a single line as 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Sending end of the board serial link; receive end is the existing sampling path.
- Driven by the CPU-side memory-mapped I/O logic: a byte is presented on IN and LOAD is pulsed.
- TX comes straight from a flip-flop so the pin is glitch-free.

---
 rtl/uart_tx.sv | 118 +++++++++++
 tb/tb_uart_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Byte-wide 8N1 UART transmitter with a registered, glitch-free
//                TX line and a BUSY flag covering the whole frame.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] IN,
    input  logic       LOAD,
    output logic       TX,
    output logic       BUSY
);

    localparam int c_bw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } t_state;

    t_state          r_state, w_state_next;
    logic [c_bw-1:0] r_baud,  w_baud_next;
    logic [2:0]      r_bit,   w_bit_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_tx,    w_tx_next;
    logic            w_bit_done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    assign w_bit_done = (r_baud == c_baud_last);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        unique case (r_state)
            S_IDLE: begin
                if (LOAD) begin
                    w_shift_next = IN;
                    w_baud_next  = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_next   = '0;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_baud_next  = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // TX is computed from the next state so the registered pin lines up with it.
    always_comb begin
        w_tx_next = 1'b1;
        unique case (w_state_next)
            S_IDLE:  w_tx_next = 1'b1;
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            S_STOP:  w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign TX   = r_tx;
    assign BUSY = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed and random frame checks for uart_tx at 4 clocks/bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_cpb   = 4;
    localparam int c_frame = 10 * c_cpb;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       load;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx #(.CLKS_PER_BIT(c_cpb)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .IN    (in_byte),
        .LOAD  (load),
        .TX    (tx),
        .BUSY  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Line level k cycles into a frame carrying b: start, 8 data LSB first, stop.
    function automatic logic expected_line(input logic [7:0] b, input int k);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        return bits[k / c_cpb];
    endfunction

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_tx"}, tx, 1'b1);
            check({tag, "_busy"}, busy, 1'b0);
            @(negedge clk);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after the frame, having checked that cycle.
    task automatic send_frame(input string tag, input logic [7:0] b,
                              input int inject_at, input bit keep_load,
                              input logic [7:0] next_in);
        in_byte = b;
        load    = 1'b1;
        @(negedge clk);
        for (int k = 0; k < c_frame; k++) begin
            check({tag, "_tx"}, tx, expected_line(b, k));
            check({tag, "_busy"}, busy, 1'b1);
            if (!keep_load && k == 0) load = 1'b0;
            if (k == inject_at) begin
                load    = 1'b1;
                in_byte = 8'hFF;
            end else if (k == inject_at + 1) begin
                load    = 1'b0;
                in_byte = 8'h3C;
            end
            if (keep_load && k == c_frame - 1) in_byte = next_in;
            @(negedge clk);
        end
        check({tag, "_gap_tx"}, tx, 1'b1);
        check({tag, "_gap_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b1;
        in_byte = 8'h00;

        // Reset held with LOAD asserted: line stays idle.
        @(negedge clk);
        check_idle("reset", 3);
        load  = 1'b0;
        rst_n = 1'b1;
        check_idle("post_reset", 3);

        // Single byte.
        send_frame("a5", 8'hA5, -10, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("a5_after", 2);

        // LOAD during a frame is ignored and no second frame follows.
        send_frame("ign", 8'h0F, 12, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("ign_after", 6);

        // LOAD held high: back-to-back frames with a single idle cycle between.
        send_frame("b2b0", 8'h00, -10, 1'b1, 8'hFF);
        send_frame("b2b1", 8'hFF, -10, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("b2b_after", 2);

        // Reset in the middle of the data bits.
        in_byte = 8'h00;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 15; k++) begin
            check("mid_tx", tx, expected_line(8'h00, k));
            check("mid_busy", busy, 1'b1);
            @(negedge clk);
        end
        check("mid_pre_tx", tx, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_tx", tx, 1'b1);
        check("mid_async_busy", busy, 1'b0);
        @(negedge clk);
        check_idle("mid_held", 2);
        rst_n = 1'b1;
        check_idle("mid_release", 2);
        send_frame("x55", 8'h55, -10, 1'b0, 8'h00);
        @(negedge clk);

        // Random bytes separated by random idle gaps.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] rb;
            int         gap;
            rb  = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            send_frame("rnd", rb, -10, 1'b0, 8'h00);
            @(negedge clk);
            check_idle("rnd_gap", gap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
